// File: rtl/nway_logic_reduce.sv
// nway_logic_reduce
//   N-input reduction gate (AND/OR/XOR/NAND/NOR/XNOR/majority) with a
//   PIPE_STAGES-deep elastic output pipeline and full valid/ready backpressure.
//   Optional feature macro: LOGIC_REDUCE_HITCNT_EN adds hit_clr/hit_count, a
//   saturating 16-bit count of delivered results with out_y=1.

module nway_logic_reduce #(
    parameter int N_IN        = 3,
    parameter int PIPE_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N_IN-1:0] in_data,
    input  logic [2:0]      in_op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_y,
    output logic [2:0]      out_op,
    output logic            out_err,
    output logic            busy
`ifdef LOGIC_REDUCE_HITCNT_EN
    ,
    input  logic            hit_clr,
    output logic [15:0]     hit_count
`endif
);

    typedef enum logic [2:0] {
        OP_AND  = 3'b000,
        OP_OR   = 3'b001,
        OP_XOR  = 3'b010,
        OP_NAND = 3'b011,
        OP_NOR  = 3'b100,
        OP_XNOR = 3'b101,
        OP_MAJ  = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    localparam int P   = PIPE_STAGES;
    localparam int PCW = $clog2(N_IN + 1);
    // Majority threshold: strictly more than half, so an even-width tie gives 0.
    localparam logic [PCW-1:0] HALF = PCW'(N_IN / 2);

    // ------------------------------------------------------------------
    // Combinational reduction of the incoming operand vector
    // ------------------------------------------------------------------
    logic [PCW-1:0] ones;
    logic           all_ones;
    logic           any_one;
    logic           parity;
    logic           maj;
    logic           res_y;
    logic           res_err;

    // Population count of the operand vector for the majority vote.
    always_comb begin
        ones = '0;
        for (int i = 0; i < N_IN; i++) begin
            ones = ones + PCW'(in_data[i]);
        end
    end

    assign all_ones = &in_data;
    assign any_one  = |in_data;
    assign parity   = ^in_data;
    assign maj      = (ones > HALF);

    // Opcode decode into the result bit and the reserved-opcode flag.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case can leave a value unassigned and infer a latch.
        res_y   = 1'b0;
        res_err = 1'b0;
        case (op_e'(in_op))
            OP_AND:  res_y = all_ones;
            OP_OR:   res_y = any_one;
            OP_XOR:  res_y = parity;
            OP_NAND: res_y = ~all_ones;
            OP_NOR:  res_y = ~any_one;
            OP_XNOR: res_y = ~parity;
            OP_MAJ:  res_y = maj;
            default: res_err = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // Elastic pipeline
    // ------------------------------------------------------------------
    logic [P-1:0] stg_v;
    logic [P-1:0] stg_y;
    logic [P-1:0] stg_err;
    logic [2:0]   stg_op [P];
    logic [P-1:0] adv;
    logic [P-1:0] ld;

    // Advance chain from the output back to stage 0: a stage moves on when
    // the stage ahead of it is empty or itself moving on.
    always_comb begin
        logic chain;
        chain      = out_ready;
        adv        = '0;
        adv[P-1]   = chain;
        for (int k = P - 2; k >= 0; k--) begin
            chain  = ~stg_v[k+1] | chain;
            adv[k] = chain;
        end
    end

    // A stage can take new content when it is empty or its content leaves.
    assign ld       = ~stg_v | adv;
    assign in_ready = ld[0];

    // Stage registers: valid bits always move, payload only with a valid item.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the payload is reset along with the valids because the
            // outputs are driven straight from the last stage and must read
            // zero after reset.
            stg_v   <= '0;
            stg_y   <= '0;
            stg_err <= '0;
            for (int k = 0; k < P; k++) begin
                stg_op[k] <= 3'b000;
            end
        end else begin
            // NOTE: non-blocking assignments so every stage samples the
            // pre-edge value of the stage behind it.
            if (ld[0]) begin
                stg_v[0] <= in_valid;
                if (in_valid) begin
                    stg_y[0]   <= res_y;
                    stg_err[0] <= res_err;
                    stg_op[0]  <= in_op;
                end
            end
            for (int k = 1; k < P; k++) begin
                if (ld[k]) begin
                    stg_v[k] <= stg_v[k-1];
                    if (stg_v[k-1]) begin
                        stg_y[k]   <= stg_y[k-1];
                        stg_err[k] <= stg_err[k-1];
                        stg_op[k]  <= stg_op[k-1];
                    end
                end
            end
        end
    end

    assign out_valid = stg_v[P-1];
    assign out_y     = stg_y[P-1];
    assign out_err   = stg_err[P-1];
    assign out_op    = stg_op[P-1];
    assign busy      = |stg_v;

`ifdef LOGIC_REDUCE_HITCNT_EN
    // Saturating count of delivered results with y=1; clear beats increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_count <= 16'h0000;
        end else if (hit_clr) begin
            hit_count <= 16'h0000;
        end else if (out_valid && out_ready && out_y && (hit_count != 16'hFFFF)) begin
            hit_count <= hit_count + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_nway_logic_reduce.sv
// tb_nway_logic_reduce
//   Two instances: A (N_IN=3, PIPE_STAGES=2) and B (N_IN=4, PIPE_STAGES=3).
//   Table-driven vectors with exact latency, directed stall/reset/counter
//   sequences, and randomized traffic against a queue-based reference model.

module tb_nway_logic_reduce;

    localparam int PA = 2;
    localparam int PB = 3;

    typedef struct {
        logic [31:0] d;
        logic [2:0]  op;
        logic        y;
        logic        err;
    } vec_t;

    typedef struct packed {
        logic       y;
        logic [2:0] op;
        logic       err;
    } res_t;

    logic clk;
    logic rst;

    logic       a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [2:0] a_in_data, a_in_op, a_out_op;
    logic       a_out_y, a_out_err, a_busy;

    logic       b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [3:0] b_in_data;
    logic [2:0] b_in_op, b_out_op;
    logic       b_out_y, b_out_err, b_busy;

`ifdef LOGIC_REDUCE_HITCNT_EN
    logic        a_hit_clr, b_hit_clr;
    logic [15:0] a_hit_count, b_hit_count;
`endif

    int total = 0;
    int bad   = 0;

    res_t qa[$];
    res_t qb[$];
    logic acc;
    logic a_hold;
    logic [4:0] a_hold_val;

    nway_logic_reduce #(.N_IN(3), .PIPE_STAGES(PA)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_op(a_in_op),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_y(a_out_y), .out_op(a_out_op), .out_err(a_out_err),
        .busy(a_busy)
`ifdef LOGIC_REDUCE_HITCNT_EN
        , .hit_clr(a_hit_clr), .hit_count(a_hit_count)
`endif
    );

    nway_logic_reduce #(.N_IN(4), .PIPE_STAGES(PB)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_op(b_in_op),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_y(b_out_y), .out_op(b_out_op), .out_err(b_out_err),
        .busy(b_busy)
`ifdef LOGIC_REDUCE_HITCNT_EN
        , .hit_clr(b_hit_clr), .hit_count(b_hit_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference result from the gate definitions, by counting ones.
    function automatic res_t ref_res(input logic [31:0] d, input int n, input logic [2:0] op);
        int   ones;
        res_t r;
        ones = 0;
        for (int i = 0; i < n; i++) ones += int'(d[i]);
        r.op  = op;
        r.err = (op == 3'd7);
        case (op)
            3'd0:    r.y = (ones == n);
            3'd1:    r.y = (ones > 0);
            3'd2:    r.y = (ones % 2 == 1);
            3'd3:    r.y = (ones != n);
            3'd4:    r.y = (ones == 0);
            3'd5:    r.y = (ones % 2 == 0);
            3'd6:    r.y = (ones > n / 2);
            default: r.y = 1'b0;
        endcase
        return r;
    endfunction

    // One clock of traffic on A, checked against the queue model.
    task automatic cyc_a(input logic iv, input logic [2:0] d, input logic [2:0] op,
                         input logic ordy, output logic accepted);
        res_t e;
        a_in_valid  = iv;
        a_in_data   = d;
        a_in_op     = op;
        a_out_ready = ordy;
        @(negedge clk);
        check("a_in_ready", a_in_ready, (qa.size() < PA) || ordy);
        check("a_busy", a_busy, qa.size() != 0);
        if (a_hold) begin
            check("a_stall_valid", a_out_valid, 1'b1);
            check("a_stall_hold", {a_out_y, a_out_op, a_out_err}, a_hold_val);
        end
        a_hold     = a_out_valid && !ordy;
        a_hold_val = {a_out_y, a_out_op, a_out_err};
        if (a_out_valid && ordy) begin
            check("a_out_pending", qa.size() != 0, 1'b1);
            if (qa.size() != 0) begin
                e = qa.pop_front();
                check("a_out_result", {a_out_y, a_out_op, a_out_err}, e);
            end
        end
        accepted = iv && a_in_ready;
        if (accepted) qa.push_back(ref_res(32'(d), 3, op));
        @(posedge clk);
        #1;
    endtask

    // One clock of traffic on B, checked against the queue model.
    task automatic cyc_b(input logic iv, input logic [3:0] d, input logic [2:0] op,
                         input logic ordy, output logic accepted);
        res_t e;
        b_in_valid  = iv;
        b_in_data   = d;
        b_in_op     = op;
        b_out_ready = ordy;
        @(negedge clk);
        check("b_in_ready", b_in_ready, (qb.size() < PB) || ordy);
        check("b_busy", b_busy, qb.size() != 0);
        if (b_out_valid && ordy) begin
            check("b_out_pending", qb.size() != 0, 1'b1);
            if (qb.size() != 0) begin
                e = qb.pop_front();
                check("b_out_result", {b_out_y, b_out_op, b_out_err}, e);
            end
        end
        accepted = iv && b_in_ready;
        if (accepted) qb.push_back(ref_res(32'(d), 4, op));
        @(posedge clk);
        #1;
    endtask

    task automatic drain_a();
        logic x;
        for (int i = 0; i < 20 && qa.size() != 0; i++) cyc_a(1'b0, 3'b000, 3'b000, 1'b1, x);
        check("a_drain_empty", qa.size(), 0);
    endtask

    task automatic drain_b();
        logic x;
        for (int i = 0; i < 20 && qb.size() != 0; i++) cyc_b(1'b0, 4'b0000, 3'b000, 1'b1, x);
        check("b_drain_empty", qb.size(), 0);
    endtask

    initial begin
        vec_t ta[16];
        vec_t tb[8];
        logic [6:0] exp_ops;
        logic ev;

        // Expected y for ops 000..110 applied to 3'b101 (bit i = op i).
        exp_ops = 7'b1101010;
        for (int i = 0; i < 8; i++) ta[i] = '{d: 32'(i), op: 3'b000, y: (i == 7), err: 1'b0};
        for (int i = 0; i < 7; i++) ta[8+i] = '{d: 32'h5, op: 3'(i), y: exp_ops[i], err: 1'b0};
        ta[15] = '{d: 32'h5, op: 3'b111, y: 1'b0, err: 1'b1};

        tb[0] = '{d: 32'b0011, op: 3'b110, y: 1'b0, err: 1'b0};
        tb[1] = '{d: 32'b0111, op: 3'b110, y: 1'b1, err: 1'b0};
        tb[2] = '{d: 32'b0000, op: 3'b110, y: 1'b0, err: 1'b0};
        tb[3] = '{d: 32'b1111, op: 3'b110, y: 1'b1, err: 1'b0};
        tb[4] = '{d: 32'b1010, op: 3'b010, y: 1'b0, err: 1'b0};
        tb[5] = '{d: 32'b1011, op: 3'b101, y: 1'b0, err: 1'b0};
        tb[6] = '{d: 32'b1111, op: 3'b011, y: 1'b0, err: 1'b0};
        tb[7] = '{d: 32'b0000, op: 3'b100, y: 1'b1, err: 1'b0};

        rst = 1'b1;
        a_in_valid = 0; a_in_data = 0; a_in_op = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = 0; b_in_op = 0; b_out_ready = 0;
        a_hold = 0; a_hold_val = 0;
`ifdef LOGIC_REDUCE_HITCNT_EN
        a_hit_clr = 0; b_hit_clr = 0;
`endif
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_a_out", {a_out_valid, a_out_y, a_out_op, a_out_err, a_busy}, 0);
        check("rst_b_out", {b_out_valid, b_out_y, b_out_op, b_out_err, b_busy}, 0);
`ifdef LOGIC_REDUCE_HITCNT_EN
        check("rst_a_hit", a_hit_count, 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_a_in_ready", a_in_ready, 1'b1);
        check("post_rst_b_in_ready", b_in_ready, 1'b1);

        // AND sweep and opcode cycle on A, one per cycle, exact latency PA
        for (int c = 0; c < 16 + PA + 1; c++) begin
            a_in_valid  = (c < 16);
            a_in_data   = (c < 16) ? ta[c].d[2:0] : 3'b000;
            a_in_op     = (c < 16) ? ta[c].op : 3'b000;
            a_out_ready = 1'b1;
            @(negedge clk);
            if (c < 16) check("tbl_a_in_ready", a_in_ready, 1'b1);
            ev = (c >= PA) && (c - PA < 16);
            check("tbl_a_out_valid", a_out_valid, ev);
            if (ev) begin
                check("tbl_a_y", a_out_y, ta[c-PA].y);
                check("tbl_a_err", a_out_err, ta[c-PA].err);
                check("tbl_a_op", a_out_op, ta[c-PA].op);
            end
            @(posedge clk);
            #1;
        end
        a_in_valid = 1'b0;

        // N_IN=4 vectors on B, exact latency PB
        for (int c = 0; c < 8 + PB + 1; c++) begin
            b_in_valid  = (c < 8);
            b_in_data   = (c < 8) ? tb[c].d[3:0] : 4'b0000;
            b_in_op     = (c < 8) ? tb[c].op : 3'b000;
            b_out_ready = 1'b1;
            @(negedge clk);
            ev = (c >= PB) && (c - PB < 8);
            check("tbl_b_out_valid", b_out_valid, ev);
            if (ev) begin
                check("tbl_b_y", b_out_y, tb[c-PB].y);
                check("tbl_b_op", b_out_op, tb[c-PB].op);
            end
            @(posedge clk);
            #1;
        end
        b_in_valid = 1'b0;

        // Stall: fill A with out_ready low, third vector held, then release
        cyc_a(1'b1, 3'b001, 3'b000, 1'b0, acc);
        check("stall_acc1", acc, 1'b1);
        cyc_a(1'b1, 3'b010, 3'b001, 1'b0, acc);
        check("stall_acc2", acc, 1'b1);
        for (int i = 0; i < 4; i++) begin
            cyc_a(1'b1, 3'b111, 3'b010, 1'b0, acc);
            check("stall_third_held", acc, 1'b0);
        end
        cyc_a(1'b1, 3'b111, 3'b010, 1'b1, acc);
        check("stall_full_pass", acc, 1'b1);
        drain_a();

        // Reset with two results in flight
        cyc_a(1'b1, 3'b111, 3'b001, 1'b0, acc);
        cyc_a(1'b1, 3'b011, 3'b110, 1'b0, acc);
        check("inflight_valid", a_out_valid, 1'b1);
        a_in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_a_valid", a_out_valid, 1'b0);
        check("midrst_a_busy", a_busy, 1'b0);
        qa.delete();
        qb.delete();
        a_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            cyc_a(1'b0, 3'b000, 3'b000, 1'b1, acc);
            check("postrst_no_stale", a_out_valid, 1'b0);
        end

        // Randomized traffic on A with phases of heavy backpressure
        for (int i = 0; i < 600; i++) begin
            cyc_a($urandom_range(0, 3) != 0, 3'($urandom), 3'($urandom),
                  ((i / 50) % 3 == 1) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0),
                  acc);
        end
        drain_a();

        // Randomized traffic on B
        for (int i = 0; i < 400; i++) begin
            cyc_b($urandom_range(0, 2) != 0, 4'($urandom), 3'($urandom),
                  $urandom_range(0, 2) != 0, acc);
        end
        drain_b();

`ifdef LOGIC_REDUCE_HITCNT_EN
        // Hit counter: five hits, then clear coincident with a sixth hit
        a_hit_clr = 1'b1;
        cyc_a(1'b0, 3'b000, 3'b000, 1'b1, acc);
        a_hit_clr = 1'b0;
        check("hit_clr0", a_hit_count, 0);
        for (int i = 0; i < 5; i++) cyc_a(1'b1, 3'b111, 3'b001, 1'b1, acc);
        drain_a();
        check("hit_five", a_hit_count, 5);
        cyc_a(1'b1, 3'b111, 3'b001, 1'b1, acc);
        cyc_a(1'b0, 3'b000, 3'b000, 1'b1, acc);
        check("hit_sixth_at_out", a_out_valid, 1'b1);
        check("hit_five_before_clr", a_hit_count, 5);
        a_hit_clr = 1'b1;
        cyc_a(1'b0, 3'b000, 3'b000, 1'b1, acc);
        a_hit_clr = 1'b0;
        check("hit_clr_wins", a_hit_count, 0);

        // Saturation
        for (int i = 0; i < 65535; i++) cyc_a(1'b1, 3'b111, 3'b001, 1'b1, acc);
        drain_a();
        check("hit_full", a_hit_count, 16'hFFFF);
        cyc_a(1'b1, 3'b111, 3'b001, 1'b1, acc);
        drain_a();
        check("hit_saturate", a_hit_count, 16'hFFFF);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
